// File: rtl/simple_cpu2_pkg.sv
// Shared widths, opcode and FSM state types for the simple_cpu2 processor.
// Optional build macro: SIMPLE_CPU2_HALT_ON_ILLEGAL_EN (illegal opcodes halt the core).
package simple_cpu2_pkg;
  localparam int DW       = 16;
  localparam int PCW      = 10;
  localparam int DAW      = 8;
  localparam int RAW      = 4;
  localparam int IM_DEPTH = 1024;
  localparam int DM_DEPTH = 256;
  localparam int NREGS    = 16;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'h0,
    OP_STORE = 4'h1,
    OP_ADD   = 4'h2,
    OP_LOADC = 4'h3,
    OP_SUBS  = 4'h4,
    OP_JMPZ  = 4'h5
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_LOAD_WB,
    ST_HALT
  } state_e;

  // Branch offset is relative to the JMPZ's own address; wraps modulo 2^PCW.
  function automatic logic [PCW-1:0] jump_target(input logic [PCW-1:0] base,
                                                 input logic [7:0] off);
    return base + {{(PCW-8){off[7]}}, off};
  endfunction
endpackage

// File: rtl/simple_cpu2_exec.sv
// Execution unit: 16-entry register bank (instance RegBank) plus the ALU that
// selects the write-back value for R[ra]. Writes land on the next clock edge.
module simple_cpu2_regbank
  import simple_cpu2_pkg::*;
(
  input  logic           clk,
  input  logic           we,
  input  logic [RAW-1:0] ra,
  input  logic [RAW-1:0] rb,
  input  logic [RAW-1:0] rc,
  input  logic [DW-1:0]  wdata,
  output logic [DW-1:0]  ra_data,
  output logic [DW-1:0]  rb_data,
  output logic [DW-1:0]  rc_data
);
  logic [DW-1:0] mem [0:NREGS-1];

  always_ff @(posedge clk) begin
    if (we) mem[ra] <= wdata;
  end

  assign ra_data = mem[ra];
  assign rb_data = mem[rb];
  assign rc_data = mem[rc];
endmodule

module simple_cpu2_exec
  import simple_cpu2_pkg::*;
(
  input  logic           clk,
  input  logic           we,
  input  opcode_e        op,
  input  logic [RAW-1:0] ra,
  input  logic [RAW-1:0] rb,
  input  logic [RAW-1:0] rc,
  input  logic [7:0]     imm8,
  input  logic [DW-1:0]  dm_data,
  output logic [DW-1:0]  ra_data,
  output logic           zero
);
  logic [DW-1:0] rb_data;
  logic [DW-1:0] rc_data;
  logic [DW-1:0] result;

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:   result = rb_data + rc_data;
      OP_SUBS:  result = rb_data - rc_data;
      OP_LOADC: result = {8'h00, imm8};
      OP_LOAD:  result = dm_data;
      default:  result = '0;
    endcase
  end

  assign zero = (ra_data == '0);

  simple_cpu2_regbank RegBank (
    .clk     (clk),
    .we      (we),
    .ra      (ra),
    .rb      (rb),
    .rc      (rc),
    .wdata   (result),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .rc_data (rc_data)
  );
endmodule

// File: rtl/simple_cpu2.sv
// Multi-cycle 16-bit CPU top: instruction/data memories, control FSM and exec unit.
// Build macro SIMPLE_CPU2_HALT_ON_ILLEGAL_EN makes opcodes 0110-1111 halt instead of NOP.
module simple_cpu2
  import simple_cpu2_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  output logic [PCW-1:0] pc
);
  state_e         state;
  logic [DW-1:0]  ir;
  logic [DW-1:0]  im_q;
  logic [DW-1:0]  dm_q;
  logic [DW-1:0]  ra_data;
  logic           zero;
  opcode_e        op;
  logic [RAW-1:0] ra;
  logic [RAW-1:0] rb;
  logic [RAW-1:0] rc;
  logic [DAW-1:0] addr8;
  logic           rf_we;
  logic           dm_we;

  assign op    = opcode_e'(ir[15:12]);
  assign ra    = ir[11:8];
  assign rb    = ir[7:4];
  assign rc    = ir[3:0];
  assign addr8 = ir[7:0];

  // Gating with rst drops any register or memory write of an interrupted instruction.
  assign rf_we = !rst && ((state == ST_EXEC &&
                           (op == OP_ADD || op == OP_SUBS || op == OP_LOADC)) ||
                          state == ST_LOAD_WB);
  assign dm_we = !rst && (state == ST_EXEC) && (op == OP_STORE);

  if (1) begin : instmem
    logic [DW-1:0] mem_array [0:IM_DEPTH-1];
    always_ff @(posedge clk) im_q <= mem_array[pc];
  end

  if (1) begin : datamemory
    logic [DW-1:0] mem_array [0:DM_DEPTH-1];
    always_ff @(posedge clk) begin
      if (dm_we) mem_array[addr8] <= ra_data;
      dm_q <= mem_array[addr8];
    end
  end

  simple_cpu2_exec execunit (
    .clk     (clk),
    .we      (rf_we),
    .op      (op),
    .ra      (ra),
    .rb      (rb),
    .rc      (rc),
    .imm8    (addr8),
    .dm_data (dm_q),
    .ra_data (ra_data),
    .zero    (zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      case (state)
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: begin
          ir    <= im_q;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          case (op)
            OP_LOAD: state <= ST_LOAD_WB;
            OP_STORE, OP_ADD, OP_LOADC, OP_SUBS: begin
              pc    <= pc + PCW'(1);
              state <= ST_FETCH;
            end
            OP_JMPZ: begin
              pc    <= zero ? jump_target(pc, addr8) : pc + PCW'(1);
              state <= ST_FETCH;
            end
            default: begin
`ifdef SIMPLE_CPU2_HALT_ON_ILLEGAL_EN
              state <= ST_HALT;
`else
              pc    <= pc + PCW'(1);
              state <= ST_FETCH;
`endif
            end
          endcase
        end
        ST_LOAD_WB: begin
          pc    <= pc + PCW'(1);
          state <= ST_FETCH;
        end
        ST_HALT:  state <= ST_HALT;
        default:  state <= ST_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_simple_cpu2.sv
// Bench for simple_cpu2: ISA-level reference model tracks pc per instruction,
// registers and data memory; directed programs plus a randomized program image.
module tb_simple_cpu2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] pc;

  simple_cpu2 dut (
    .clk (clk),
    .rst (rst),
    .pc  (pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_im [1024];
  logic [15:0] m_dm [256];
  logic [15:0] m_rf [16];
  int          m_pc;
  bit          m_halt;
  logic [9:0]  exp_q [$];

  task automatic new_image();
    for (int i = 0; i < 1024; i++) m_im[i] = 16'h6000;
    for (int i = 0; i < 256; i++)  m_dm[i] = 16'($urandom);
    for (int i = 0; i < 16; i++)   m_rf[i] = 16'($urandom);
  endtask

  task automatic load_dut();
    for (int i = 0; i < 1024; i++) dut.instmem.mem_array[i] <= m_im[i];
    for (int i = 0; i < 256; i++)  dut.datamemory.mem_array[i] <= m_dm[i];
    for (int i = 0; i < 16; i++)   dut.execunit.RegBank.mem[i] <= m_rf[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    load_dut();
    m_pc   = 0;
    m_halt = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (pc !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_pc actual=%0d required=0", pc);
    end
    rst = 1'b0;
  endtask

  // Executes one instruction of the architectural model; returns its cycle count.
  task automatic step_model(output int cyc);
    logic [15:0] instr;
    int op, ra, rb, rc, a8, off, npc;
    instr = m_im[m_pc];
    op = int'(instr[15:12]); ra = int'(instr[11:8]);
    rb = int'(instr[7:4]);   rc = int'(instr[3:0]);
    a8 = int'(instr[7:0]);
    cyc = 3;
    npc = (m_pc + 1) % 1024;
    if (m_halt) begin
      npc = m_pc;
    end else begin
      case (op)
        0: begin m_rf[ra] = m_dm[a8]; cyc = 4; end
        1: m_dm[a8] = m_rf[ra];
        2: m_rf[ra] = m_rf[rb] + m_rf[rc];
        3: m_rf[ra] = 16'(a8);
        4: m_rf[ra] = m_rf[rb] - m_rf[rc];
        5: begin
          off = (a8 > 127) ? a8 - 256 : a8;
          if (m_rf[ra] == 16'd0) npc = (m_pc + off + 1024) % 1024;
        end
        default: begin
`ifdef SIMPLE_CPU2_HALT_ON_ILLEGAL_EN
          m_halt = 1'b1;
          npc = m_pc;
`endif
        end
      endcase
    end
    m_pc = npc;
    exp_q.push_back(10'(npc));
  endtask

  task automatic run_instr(input int n);
    int cyc;
    logic [9:0] old_pc, want;
    for (int k = 0; k < n; k++) begin
      old_pc = 10'(m_pc);
      step_model(cyc);
      want = exp_q.pop_front();
      repeat (cyc - 1) @(posedge clk);
      #1;
      n_checks++;
      if (pc !== old_pc) begin
        n_fail++;
        $display("FAIL pc_hold actual=%0d required=%0d", pc, old_pc);
      end
      @(posedge clk); #1;
      n_checks++;
      if (pc !== want) begin
        n_fail++;
        $display("FAIL pc_next from=%0d actual=%0d required=%0d", old_pc, pc, want);
      end
    end
  endtask

  task automatic check_state();
    for (int r = 0; r < 16; r++) begin
      n_checks++;
      if (dut.execunit.RegBank.mem[r] !== m_rf[r]) begin
        n_fail++;
        $display("FAIL reg R%0d actual=%h required=%h", r, dut.execunit.RegBank.mem[r], m_rf[r]);
      end
    end
    for (int a = 0; a < 256; a++) begin
      n_checks++;
      if (dut.datamemory.mem_array[a] !== m_dm[a]) begin
        n_fail++;
        $display("FAIL dmem D%0d actual=%h required=%h", a, dut.datamemory.mem_array[a], m_dm[a]);
      end
    end
  endtask

  task automatic check_d(input string name, input int a, input logic [15:0] want);
    n_checks++;
    if (dut.datamemory.mem_array[a] !== want) begin
      n_fail++;
      $display("FAIL %s D%0d actual=%h required=%h", name, a, dut.datamemory.mem_array[a], want);
    end
  endtask

  task automatic check_r(input string name, input int r, input logic [15:0] want);
    n_checks++;
    if (dut.execunit.RegBank.mem[r] !== want) begin
      n_fail++;
      $display("FAIL %s R%0d actual=%h required=%h", name, r, dut.execunit.RegBank.mem[r], want);
    end
  endtask

  task automatic test_reset();
    new_image();
    m_im[0] = 16'h3001;
    do_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (pc !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_hold_pc actual=%0d required=0", pc);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_sum();
    new_image();
    m_dm[5] = 16'd141; m_dm[6] = 16'd101; m_dm[7] = 16'd18;
    m_im[0] = 16'h0005; m_im[1] = 16'h0106; m_im[2] = 16'h0207;
    m_im[3] = 16'h2001; m_im[4] = 16'h2002; m_im[5] = 16'h1005;
    do_reset();
    run_instr(6);
    check_d("sum", 5, 16'h0104);
    check_state();
  endtask

  task automatic test_loadc_add();
    new_image();
    m_im[0] = 16'h3001; m_im[1] = 16'h3101; m_im[2] = 16'h3201;
    m_im[3] = 16'h2012; m_im[4] = 16'h1000;
    do_reset();
    run_instr(5);
    check_r("loadc_add", 1, 16'h0001);
    check_r("loadc_add", 2, 16'h0001);
    check_d("loadc_add", 0, 16'h0002);
    check_state();
  endtask

  task automatic test_subs(input logic [15:0] sub_instr, input logic [15:0] want);
    new_image();
    m_im[0] = 16'h3101; m_im[1] = 16'h3203; m_im[2] = sub_instr; m_im[3] = 16'h1000;
    do_reset();
    run_instr(4);
    check_d("subs", 0, want);
    check_state();
  endtask

  task automatic test_alias();
    new_image();
    m_im[0] = 16'h3003; m_im[1] = 16'h2000; m_im[2] = 16'h1000;
    do_reset();
    run_instr(3);
    check_d("alias_double", 0, 16'h0006);
  endtask

  task automatic test_jmpz(input bit taken);
    new_image();
    m_im[0] = 16'h3101; m_im[1] = 16'h3202; m_im[2] = 16'h3000;
    m_im[3] = taken ? 16'h5002 : 16'h5102;
    m_im[4] = 16'h1100; m_im[5] = 16'h1200;
    do_reset();
    if (taken) begin
      run_instr(5);
      check_d("jmpz_taken", 0, 16'h0002);
    end else begin
      run_instr(5);
      check_d("jmpz_not_taken_mid", 0, 16'h0001);
      run_instr(1);
      check_d("jmpz_not_taken_end", 0, 16'h0002);
    end
    check_state();
  endtask

  task automatic test_loop();
    new_image();
    m_im[0] = 16'h3000; m_im[1] = 16'h3101; m_im[2] = 16'h3200;
    m_im[3] = 16'h2001; m_im[4] = 16'h52FF;
    do_reset();
    run_instr(3);
    for (int k = 1; k <= 3; k++) begin
      run_instr(2);
      check_r("loop_count", 0, 16'(k));
    end
  endtask

  task automatic test_loop_wrap();
    new_image();
    m_rf[0] = 16'hFFFD;
    m_im[0] = 16'h3101; m_im[1] = 16'h3200; m_im[2] = 16'h2001; m_im[3] = 16'h52FF;
    do_reset();
    run_instr(2);
    for (int k = 1; k <= 5; k++) begin
      run_instr(2);
      check_r("loop_wrap", 0, 16'((32'hFFFD + k) & 32'hFFFF));
    end
  endtask

  task automatic test_reset_mid_load();
    new_image();
    m_im[0] = 16'h0105; m_rf[1] = 16'h1234; m_dm[5] = 16'hBEEF;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_r("mid_load_reg", 1, 16'h1234);
    n_checks++;
    if (pc !== 10'd0) begin
      n_fail++;
      $display("FAIL mid_load_pc actual=%0d required=0", pc);
    end
    rst = 1'b0;
    m_pc = 0;
    run_instr(1);
    check_r("mid_load_rerun", 1, 16'hBEEF);
  endtask

  task automatic test_reset_mid_store();
    new_image();
    m_im[0] = 16'h1305; m_rf[3] = 16'hA5A5; m_dm[5] = 16'h0F0F;
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_d("mid_store_blocked", 5, 16'h0F0F);
    rst = 1'b0;
    m_pc = 0;
    run_instr(1);
    check_d("mid_store_rerun", 5, 16'hA5A5);
  endtask

  task automatic test_random();
    int sel, op;
    new_image();
    for (int i = 0; i < 1024; i++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1:    op = 0;
        2, 3:    op = 1;
        4, 5:    op = 2;
        6, 7:    op = 3;
        8:       op = 4;
        9, 10:   op = 5;
        default: op = $urandom_range(6, 15);
      endcase
`ifdef SIMPLE_CPU2_HALT_ON_ILLEGAL_EN
      if (op > 5) op = 4;
`endif
      m_im[i] = {4'(op), 12'($urandom)};
      if (op == 3) m_im[i][7:0] = 8'($urandom_range(0, 3));
    end
    for (int r = 0; r < 16; r++) m_rf[r] = 16'($urandom_range(0, 4));
    do_reset();
    run_instr(400);
    check_state();
  endtask

  initial begin
    test_reset();
    test_sum();
    test_loadc_add();
    test_subs(16'h4021, 16'h0002);
    test_subs(16'h4012, 16'hFFFE);
    test_alias();
    test_jmpz(1'b1);
    test_jmpz(1'b0);
    test_loop();
    test_loop_wrap();
    test_reset_mid_load();
    test_reset_mid_store();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
